// File: rtl/wb_hub_pkg.sv
// Shared types and default parameters for the CPU-to-Wishbone hub.
package wb_hub_pkg;

  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_AW      = 8;
  localparam int unsigned DEF_NSLV    = 4;
  localparam int unsigned DEF_SEL_LSB = 4;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    DONE
  } state_t;

endpackage

// File: rtl/wb_hub_rdmux.sv
// Selects the addressed slave's read data and ack bit; out-of-range sel yields zeros.
module wb_hub_rdmux
  import wb_hub_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned NSLV = DEF_NSLV,
  parameter int unsigned SW   = DEF_AW - DEF_SEL_LSB
) (
  input  logic [NSLV*DW-1:0] wb_dati,
  input  logic [NSLV-1:0]    wb_acki,
  input  logic [SW-1:0]      sel,
  output logic [DW-1:0]      dat_c,
  output logic               ack_c
);

  always_comb begin
    dat_c = '0;
    ack_c = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel == SW'(i)) begin
        dat_c = wb_dati[i*DW +: DW];
        ack_c = wb_acki[i];
      end
    end
  end

endmodule

// File: rtl/wb_hub.sv
// CPU register port to NSLV Wishbone slaves: address decode, one-hot strobe,
// ack/timeout completion and a single rdy pulse per cs assertion.
module wb_hub
  import wb_hub_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned NSLV    = DEF_NSLV,
  parameter int unsigned SEL_LSB = DEF_SEL_LSB,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      din,
  output logic [DW-1:0]      dout,
  output logic               rdy,
  output logic               err,
  output logic [NSLV-1:0]    wb_stbo,
  output logic [AW-1:0]      wb_adro,
  output logic               wb_rwo,
  output logic [DW-1:0]      wb_dato,
  input  logic [NSLV-1:0]    wb_acki,
  input  logic [NSLV*DW-1:0] wb_dati
);

  localparam int unsigned SW      = AW - SEL_LSB;
  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_in;
  logic          sel_ok_c;
  logic [CW-1:0] cnt;
  logic [DW-1:0] slv_dat_c;
  logic          slv_ack_c;

  assign sel_in   = addr[AW-1:SEL_LSB];
  assign sel_ok_c = (32'(sel_in) < NSLV);

  wb_hub_rdmux #(
    .DW   (DW),
    .NSLV (NSLV),
    .SW   (SW)
  ) u_rdmux (
    .wb_dati (wb_dati),
    .wb_acki (wb_acki),
    .sel     (sel),
    .dat_c   (slv_dat_c),
    .ack_c   (slv_ack_c)
  );

  // Ack is tested before the timeout so a coincident ack completes without error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      wb_stbo <= '0;
      wb_adro <= '0;
      wb_rwo  <= 1'b0;
      wb_dato <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
      dout    <= '0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) begin
            wb_adro <= addr;
            wb_dato <= din;
            wb_rwo  <= we;
            sel     <= sel_in;
            cnt     <= '0;
            if (sel_ok_c) begin
              wb_stbo <= NSLV'(1) << sel_in;
              state   <= STROBE;
            end else begin
              rdy   <= 1'b1;
              err   <= 1'b1;
              dout  <= '0;
              state <= DONE;
            end
          end
        end
        STROBE: begin
          if (slv_ack_c) begin
            wb_stbo <= '0;
            rdy     <= 1'b1;
            dout    <= slv_dat_c;
            state   <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == CW'(TO_LAST))) begin
            wb_stbo <= '0;
            rdy     <= 1'b1;
            err     <= 1'b1;
            dout    <= '0;
            state   <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!cs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_hub.sv
// Randomized self-checking bench for wb_hub against a transaction-level model.
module tb_wb_hub;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int NSLV = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rdy;
  logic          err;
  logic [NSLV-1:0] wb_stbo;
  logic [AW-1:0]   wb_adro;
  logic            wb_rwo;
  logic [DW-1:0]   wb_dato;
  logic [NSLV-1:0] wb_acki;
  logic [NSLV*DW-1:0] wb_dati;

  int errors = 0;
  int checks = 0;
  logic [7:0] sdat [NSLV];

  always #5 clk = ~clk;

  wb_hub #(
    .DW(DW), .AW(AW), .NSLV(NSLV), .SEL_LSB(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .rdy(rdy), .err(err),
    .wb_stbo(wb_stbo), .wb_adro(wb_adro), .wb_rwo(wb_rwo), .wb_dato(wb_dato),
    .wb_acki(wb_acki), .wb_dati(wb_dati)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One CPU transaction. ack_at = strobe cycle index (0-based) at which the
  // selected slave acks; >= TO means it never acks. hold = extra cs cycles after rdy.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input int ack_at, input int hold, input int fdat);
    int sel, len, rdy_cyc, cs_low;
    logic exp_err;
    logic [7:0] exp_dout;
    logic [3:0] exp_stb;
    logic [3:0] ak;
    sel = int'(a[7:4]);
    if (sel >= NSLV) begin
      len = 0; exp_err = 1'b1;
    end else if (ack_at < TO) begin
      len = ack_at + 1; exp_err = 1'b0;
    end else begin
      len = TO; exp_err = 1'b1;
    end
    rdy_cyc = len + 1;
    cs_low  = rdy_cyc + 1 + hold;
    for (int i = 0; i < NSLV; i++) sdat[i] = 8'($urandom);
    if (fdat >= 0 && sel < NSLV) sdat[sel] = 8'(fdat);
    exp_dout = exp_err ? 8'h00 : sdat[sel];

    @(posedge clk); #1;
    cs = 1'b1; we = w; addr = a; din = d;
    wb_acki = 4'($urandom);
    wb_dati = {sdat[3], sdat[2], sdat[1], sdat[0]};
    for (int k = 1; k <= cs_low; k++) begin
      @(posedge clk); #1;
      if (k == cs_low) cs = 1'b0;
      addr = 8'($urandom);
      din  = 8'($urandom);
      we   = 1'($urandom);
      ak = 4'($urandom);
      if (sel < NSLV && k <= len) ak[sel] = (k - 1 == ack_at);
      wb_acki = ak;
      @(negedge clk);
      exp_stb = (k <= len) ? 4'(1 << sel) : 4'b0000;
      chk("stb", 32'(wb_stbo), 32'(exp_stb));
      chk("rdy", 32'(rdy), 32'(k == rdy_cyc));
      if (k == rdy_cyc) begin
        chk("err", 32'(err), 32'(exp_err));
        chk("dout", 32'(dout), 32'(exp_dout));
      end
      chk("adr", 32'(wb_adro), 32'(a));
      chk("rw", 32'(wb_rwo), 32'(w));
      chk("dat", 32'(wb_dato), 32'(d));
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_stb", 32'(wb_stbo), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_adr", 32'(wb_adro), 32'h0);
    chk("rst_rw", 32'(wb_rwo), 32'h0);
    chk("rst_dat", 32'(wb_dato), 32'h0);
  endtask

  // Reset asserted during the second strobe cycle of a never-acked read.
  task automatic reset_mid_strobe();
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; addr = 8'h15; din = 8'h00; wb_acki = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_stb1", 32'(wb_stbo), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_stb2", 32'(wb_stbo), 32'h2);
    @(posedge clk); #1;
    rst = 1'b0; cs = 1'b0;
    @(negedge clk);
    chk_reset_state();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    wb_acki = '0; wb_dati = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(1'b0, 8'h12, 8'h00, 0, 0, 8'hA5);
    run_txn(1'b1, 8'h03, 8'h5C, 2, 0, -1);
    run_txn(1'b0, 8'h70, 8'h11, 0, 1, -1);
    run_txn(1'b0, 8'h25, 8'h00, 100, 0, -1);
    run_txn(1'b1, 8'h31, 8'h77, TO - 1, 0, -1);
    run_txn(1'b0, 8'h0A, 8'h00, 1, 18, -1);
    reset_mid_strobe();
    run_txn(1'b0, 8'h12, 8'h00, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), {4'($urandom_range(0, 5)), 4'($urandom)}, 8'($urandom),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
